// File: rtl/uk101_pkg.sv
// Shared uk101 definitions: PS/2 frame layout, transmitter FSM states, frame builder.
package uk101_pkg;

  localparam int unsigned PS2_DATA_W     = 8;
  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_STOP_IDX   = 10;
  localparam int unsigned PS2_IDX_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    INHIBIT
  } ps2_tx_state_t;

  // Frame payload, LSB (start bit) first on the wire.
  typedef struct packed {
    logic                  stop;
    logic                  parity;
    logic [PS2_DATA_W-1:0] data;
    logic                  start;
  } ps2_frame_t;

  // Build an 11-bit frame with odd parity.
  function automatic ps2_frame_t ps2_frame(input logic [PS2_DATA_W-1:0] data);
    ps2_frame_t f;
    f.start  = 1'b0;
    f.data   = data;
    f.parity = ~^data;
    f.stop   = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Byte-queue handshake into the PS/2 keyboard transmitter.
interface ps2_kbd_tx_if;
  import uk101_pkg::*;

  logic [PS2_DATA_W-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full and a registered head port.
// The head is read one cycle after it lands, so empty deasserts one cycle
// after the first push into an empty queue.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;
  logic             head_valid_q;
  logic [WIDTH-1:0] head_q;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign push_ok_c = push && !full_q;
  assign pop_ok_c  = pop && (count_q != '0);

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointers, count, flags and registered head.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q      <= count_d;
      full_q       <= (count_d == CNT_W'(DEPTH));
      head_q       <= mem[rd_ptr_q];
      head_valid_q <= (count_q != '0) && !pop_ok_c;
    end
  end

  assign head  = head_q;
  assign count = count_q;
  assign full  = full_q;
  assign empty = !head_valid_q;

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard serializer: queued bytes out as 11-bit frames,
// with host-inhibit abort and full-frame retransmission.
module ps2_kbd_tx
  import uk101_pkg::*;
#(
  parameter int unsigned PS2_HALF   = 2000,
  parameter int unsigned GAP        = 4000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        n_reset,
  ps2_kbd_tx_if.slave                 tx,
  input  logic                        ps2_clk_in,
  output logic                        ps2_clk_out,
  output logic                        ps2_data_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_done
);

  localparam int unsigned HALF_W = $clog2(PS2_HALF);
  localparam int unsigned GAP_W  = $clog2(GAP + 1);
  localparam logic [HALF_W-1:0]    HALF_LOAD = HALF_W'(PS2_HALF - 1);
  localparam logic [GAP_W-1:0]     GAP_LOAD  = GAP_W'(GAP);
  localparam logic [PS2_IDX_W-1:0] STOP_IDX  = PS2_IDX_W'(PS2_STOP_IDX);

  ps2_tx_state_t             state_q, state_d;
  logic [HALF_W-1:0]         half_q, half_d;
  logic [GAP_W-1:0]          gap_q, gap_d;
  logic [PS2_IDX_W-1:0]      idx_q, idx_d;
  logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
  logic                      clk_out_q, clk_out_d;
  logic                      data_out_q, data_out_d;
  logic                      done_q, done_d;
  logic                      clk_meta_q, clk_s;

  logic                      push_c;
  logic                      pop_c;
  logic [PS2_DATA_W-1:0]     fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;

  assign push_c      = tx.tx_valid && !fifo_full;
  assign tx.tx_ready = !fifo_full;

  sync_fifo #(
    .WIDTH (PS2_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .n_reset   (n_reset),
    .push      (push_c),
    .push_data (tx.tx_data),
    .pop       (pop_c),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Two-flop synchronizer for the sensed line clock; resets to released.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      clk_meta_q <= 1'b1;
      clk_s      <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_s      <= clk_meta_q;
    end
  end

  // State, counters and registered line drives.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      half_q     <= '0;
      gap_q      <= '0;
      idx_q      <= '0;
      frame_q    <= '1;
      clk_out_q  <= 1'b1;
      data_out_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      gap_q      <= gap_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      clk_out_q  <= clk_out_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

  // Next-state, counter and line-drive logic; data changes only on entry to HIGH.
  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    gap_d      = gap_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    clk_out_d  = clk_out_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    pop_c      = 1'b0;

    case (state_q)
      IDLE: begin
        clk_out_d  = 1'b1;
        data_out_d = 1'b1;
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (!fifo_empty && clk_s) begin
          frame_d    = ps2_frame(fifo_head);
          idx_d      = '0;
          half_d     = HALF_LOAD;
          data_out_d = frame_d[0];
          state_d    = HIGH;
        end
      end

      HIGH: begin
        clk_out_d = 1'b1;
        if (!clk_s && (idx_q < STOP_IDX)) begin
          data_out_d = 1'b1;
          state_d    = INHIBIT;
        end else if (half_q == '0) begin
          clk_out_d = 1'b0;
          half_d    = HALF_LOAD;
          state_d   = LOW;
        end else begin
          half_d = half_q - HALF_W'(1);
        end
      end

      LOW: begin
        clk_out_d = 1'b0;
        if (half_q != '0) begin
          half_d = half_q - HALF_W'(1);
        end else if (idx_q == STOP_IDX) begin
          pop_c      = 1'b1;
          done_d     = 1'b1;
          clk_out_d  = 1'b1;
          data_out_d = 1'b1;
          gap_d      = GAP_LOAD;
          state_d    = IDLE;
        end else begin
          idx_d      = idx_q + PS2_IDX_W'(1);
          data_out_d = frame_q[idx_d];
          clk_out_d  = 1'b1;
          half_d     = HALF_LOAD;
          state_d    = HIGH;
        end
      end

      INHIBIT: begin
        clk_out_d  = 1'b1;
        data_out_d = 1'b1;
        if (clk_s) begin
          gap_d   = GAP_LOAD;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign ps2_clk_out  = clk_out_q;
  assign ps2_data_out = data_out_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx with PS2_HALF=4, GAP=8, FIFO_DEPTH=8.
module tb_ps2_kbd_tx;

  localparam int unsigned HALF  = 4;
  localparam int unsigned GAP   = 8;
  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       ps2_clk_in = 1'b1;
  logic       ps2_clk_out;
  logic       ps2_data_out;
  logic       frame_done;
  logic [3:0] fifo_count;

  ps2_kbd_tx_if tx_if ();

  ps2_kbd_tx #(
    .PS2_HALF   (HALF),
    .GAP        (GAP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .tx           (tx_if),
    .ps2_clk_in   (ps2_clk_in),
    .ps2_clk_out  (ps2_clk_out),
    .ps2_data_out (ps2_data_out),
    .fifo_count   (fifo_count),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;

  // Line monitor state, updated only by step().
  int   cyc = 0;
  logic prev_clk = 1'b1;
  logic prev_data = 1'b1;
  logic bitq[$];
  int   fall_cnt = 0;
  int   done_cnt = 0;
  int   start_cnt = 0;
  int   start_cyc = 0;
  int   done_cyc = 0;
  int   idle_run = 0;
  int   min_idle = 1000;

  // Hand-computed frames {stop, parity, data, start} for bytes 0x01..0x09.
  logic [10:0] burst_exp [9] = '{11'h402, 11'h404, 11'h606, 11'h408, 11'h60A,
                                 11'h60C, 11'h40E, 11'h410, 11'h612};

  task automatic step();
    @(negedge clk);
    cyc++;
    if (prev_clk && !ps2_clk_out) begin
      bitq.push_back(ps2_data_out);
      fall_cnt++;
    end
    if (prev_clk && ps2_clk_out && prev_data && !ps2_data_out) begin
      start_cnt++;
      start_cyc = cyc;
      if (idle_run < min_idle) min_idle = idle_run;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    idle_run  = (ps2_clk_out && ps2_data_out) ? idle_run + 1 : 0;
    prev_clk  = ps2_clk_out;
    prev_data = ps2_data_out;
  endtask

  task automatic mon_clear();
    bitq.delete();
    fall_cnt  = 0;
    done_cnt  = 0;
    start_cnt = 0;
    min_idle  = 1000;
  endtask

  function automatic logic [10:0] frame_at(input int k);
    logic [10:0] f;
    for (int i = 0; i < 11; i++) begin
      f[i] = (k * 11 + i < bitq.size()) ? bitq[k * 11 + i] : 1'bx;
    end
    return f;
  endfunction

  task automatic push_byte(input logic [7:0] b, output int acc_cyc);
    logic rdy;
    bit   ok;
    ok = 1'b0;
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      rdy = tx_if.tx_ready;
      step();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    tx_if.tx_valid = 1'b0;
    acc_cyc = cyc;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL push_timeout: byte %02h not accepted, ready=%b required 1", b, tx_if.tx_ready);
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) step();
    n_cmp++;
    if (done_cnt < target) begin
      n_bad++;
      $display("FAIL wait_done: frame_done count %0d required %0d", done_cnt, target);
    end
  endtask

  task automatic wait_falls(input int target, input int budget);
    for (int i = 0; i < budget && fall_cnt < target; i++) step();
    n_cmp++;
    if (fall_cnt < target) begin
      n_bad++;
      $display("FAIL wait_falls: clock falls %0d required %0d", fall_cnt, target);
    end
  endtask

  task automatic test_reset();
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    n_reset = 1'b0;
    repeat (3) step();
    n_cmp++; if (ps2_clk_out !== 1'b1) begin n_bad++; $display("FAIL rst_clk_out: got %b required 1", ps2_clk_out); end
    n_cmp++; if (ps2_data_out !== 1'b1) begin n_bad++; $display("FAIL rst_data_out: got %b required 1", ps2_data_out); end
    n_cmp++; if (tx_if.tx_ready !== 1'b1) begin n_bad++; $display("FAIL rst_tx_ready: got %b required 1", tx_if.tx_ready); end
    n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL rst_fifo_count: got %0d required 0", fifo_count); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_frame_done: got %b required 0", frame_done); end
    n_reset = 1'b1;
    repeat (4) step();
    n_cmp++; if (ps2_clk_out !== 1'b1 || ps2_data_out !== 1'b1) begin n_bad++; $display("FAIL post_rst_idle: got clk=%b data=%b required 1/1", ps2_clk_out, ps2_data_out); end
  endtask

  task automatic test_single_1c();
    int acc;
    mon_clear();
    push_byte(8'h1C, acc);
    n_cmp++; if (fifo_count !== 4'd1) begin n_bad++; $display("FAIL 1c_count_queued: got %0d required 1", fifo_count); end
    wait_done(1, 200);
    repeat (20) step();
    n_cmp++; if (fall_cnt !== 11) begin n_bad++; $display("FAIL 1c_falls: got %0d required 11", fall_cnt); end
    n_cmp++; if (frame_at(0) !== 11'h438) begin n_bad++; $display("FAIL 1c_frame: got %03h required 438", frame_at(0)); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL 1c_done_count: got %0d required 1", done_cnt); end
    n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL 1c_count_drained: got %0d required 0", fifo_count); end
  endtask

  task automatic test_zero_timing();
    int acc;
    mon_clear();
    push_byte(8'h00, acc);
    step();
    n_cmp++; if (ps2_data_out !== 1'b1) begin n_bad++; $display("FAIL zero_start_early: data got %b required 1 at N+1", ps2_data_out); end
    step();
    n_cmp++; if (ps2_data_out !== 1'b0 || ps2_clk_out !== 1'b1) begin n_bad++; $display("FAIL zero_start_bit: got clk=%b data=%b required 1/0 at N+2", ps2_clk_out, ps2_data_out); end
    repeat (3) step();
    n_cmp++; if (ps2_clk_out !== 1'b1) begin n_bad++; $display("FAIL zero_clk_early: got %b required 1 at N+5", ps2_clk_out); end
    step();
    n_cmp++; if (ps2_clk_out !== 1'b0) begin n_bad++; $display("FAIL zero_first_fall: got %b required 0 at N+6", ps2_clk_out); end
    wait_done(1, 200);
    n_cmp++; if (done_cyc - acc !== 90) begin n_bad++; $display("FAIL zero_done_latency: got %0d required 90", done_cyc - acc); end
    repeat (20) step();
    n_cmp++; if (frame_at(0) !== 11'h600) begin n_bad++; $display("FAIL zero_frame: got %03h required 600", frame_at(0)); end
  endtask

  task automatic test_back_to_back();
    int acc;
    mon_clear();
    for (int i = 1; i <= 8; i++) push_byte(8'(i), acc);
    n_cmp++; if (tx_if.tx_ready !== 1'b0) begin n_bad++; $display("FAIL burst_ready_full: got %b required 0", tx_if.tx_ready); end
    n_cmp++; if (fifo_count !== 4'd8) begin n_bad++; $display("FAIL burst_count_full: got %0d required 8", fifo_count); end
    push_byte(8'h09, acc);
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL burst_ninth_after_pop: done count %0d required 1", done_cnt); end
    wait_done(9, 2000);
    repeat (20) step();
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (frame_at(k) !== burst_exp[k]) begin
        n_bad++;
        $display("FAIL burst_frame_%0d: got %03h required %03h", k, frame_at(k), burst_exp[k]);
      end
    end
    n_cmp++; if (start_cnt !== 9) begin n_bad++; $display("FAIL burst_starts: got %0d required 9", start_cnt); end
    n_cmp++; if (min_idle < 8) begin n_bad++; $display("FAIL burst_gap: min idle %0d required >= 8", min_idle); end
    n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL burst_drained: got %0d required 0", fifo_count); end
  endtask

  task automatic test_inhibit();
    int acc;
    int f0;
    int rel;
    mon_clear();
    push_byte(8'hF0, acc);
    wait_falls(5, 200);
    repeat (4) step();
    ps2_clk_in = 1'b0;
    f0 = fall_cnt;
    repeat (3) step();
    n_cmp++; if (ps2_clk_out !== 1'b1 || ps2_data_out !== 1'b1) begin n_bad++; $display("FAIL inh_react: got clk=%b data=%b required 1/1", ps2_clk_out, ps2_data_out); end
    repeat (47) step();
    n_cmp++; if (fall_cnt !== f0) begin n_bad++; $display("FAIL inh_no_clock: falls %0d required %0d", fall_cnt, f0); end
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL inh_no_done: got %0d required 0", done_cnt); end
    bitq.delete();
    fall_cnt = 0;
    ps2_clk_in = 1'b1;
    rel = cyc;
    wait_done(1, 300);
    repeat (20) step();
    n_cmp++; if (start_cyc - rel < 8) begin n_bad++; $display("FAIL inh_restart_gap: got %0d required >= 8", start_cyc - rel); end
    n_cmp++; if (fall_cnt !== 11) begin n_bad++; $display("FAIL inh_retx_falls: got %0d required 11", fall_cnt); end
    n_cmp++; if (frame_at(0) !== 11'h7E0) begin n_bad++; $display("FAIL inh_retx_frame: got %03h required 7E0", frame_at(0)); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL inh_done_once: got %0d required 1", done_cnt); end
  endtask

  task automatic test_stop_inhibit();
    int acc;
    mon_clear();
    push_byte(8'h1C, acc);
    wait_falls(10, 200);
    repeat (4) step();
    ps2_clk_in = 1'b0;
    wait_done(1, 100);
    repeat (5) step();
    n_cmp++; if (fall_cnt !== 11) begin n_bad++; $display("FAIL stop_inh_falls: got %0d required 11", fall_cnt); end
    n_cmp++; if (frame_at(0) !== 11'h438) begin n_bad++; $display("FAIL stop_inh_frame: got %03h required 438", frame_at(0)); end
    ps2_clk_in = 1'b1;
    repeat (30) step();
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL stop_inh_done_once: got %0d required 1", done_cnt); end
    n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL stop_inh_drained: got %0d required 0", fifo_count); end
  endtask

  task automatic test_reset_mid_frame();
    int acc;
    mon_clear();
    push_byte(8'hAA, acc);
    push_byte(8'h55, acc);
    push_byte(8'h12, acc);
    wait_falls(3, 200);
    step();
    n_cmp++; if (ps2_clk_out !== 1'b0) begin n_bad++; $display("FAIL midrst_pre_low: got %b required 0", ps2_clk_out); end
    n_reset = 1'b0;
    #1;
    n_cmp++; if (ps2_clk_out !== 1'b1 || ps2_data_out !== 1'b1) begin n_bad++; $display("FAIL midrst_lines: got clk=%b data=%b required 1/1", ps2_clk_out, ps2_data_out); end
    n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL midrst_count: got %0d required 0", fifo_count); end
    n_cmp++; if (tx_if.tx_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b required 1", tx_if.tx_ready); end
    repeat (3) step();
    n_reset = 1'b1;
    mon_clear();
    repeat (300) step();
    n_cmp++; if (fall_cnt !== 0 || done_cnt !== 0) begin n_bad++; $display("FAIL midrst_silent: falls %0d done %0d required 0/0", fall_cnt, done_cnt); end
  endtask

  initial begin
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    test_reset();
    test_single_1c();
    test_zero_timing();
    test_back_to_back();
    test_inhibit();
    test_stop_inhibit();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
